ltc2308_scan_ctrl: RTL
======================

Name: ltc2308_scan_ctrl

Overview:
- Sequences the LTC2308 8-channel 12-bit SPI ADC on the DE1-SoC ADC header (ADC_CS_N used as CONVST, plus ADC_SCLK, ADC_DIN and ADC_DOUT).
- Sweeps a masked set of channels, either as one sweep per start pulse or continuously.
- Handles the ADC's one-frame config/result pipeline.
- Presents each result on a valid/ready stream for the HPS-side PIO/FIFO or fabric logic; runs on the 50 MHz board clock.

Parameters:
- CLK_DIV, 2, CLOCK_50 cycles per SCLK half-period (SCLK = 50/(2*CLK_DIV) MHz); legal 1..255.
- CONV_CYCLES, 80, cycles CONVST is held high per conversion (≥1.6 us tCONV); legal 2..1023.

Ports:
- clk_clk  in  1  board clock (CLOCK_50).
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin one sweep (ignored unless IDLE).
- continuous  in  1  when 1, sweeps repeat back-to-back.
- chan_mask  in  8  channel enable bits, bit n = CHn.
- unipolar  in  1  UNI bit of config word (1 = 0..4.096 V straight binary).
- busy  out  1  high in any state except IDLE.
- result_valid  out  1  result stream valid.
- result_ready  in  1  result stream ready.
- result_data  out  12  conversion result, MSB first as received.
- result_chan  out  3  channel the result belongs to.
- adc_convst  out  1  to ADC_CS_N (CONVST).
- adc_sclk  out  1  to ADC_SCLK.
- adc_din  out  1  to ADC_DIN.
- adc_dout  in  1  from ADC_DOUT; sampled directly, with no synchronizer (source-synchronous).

Behaviour:
- Reset (async, any state): state=IDLE; adc_convst, adc_sclk, adc_din, busy and result_valid = 0; result_data, result_chan = 0. Sample mask, counters and prime flag are cleared.
- States:
  - IDLE: leaves when (start or continuous) and chan_mask≠0.
    - Latches chan_mask into sweep_mask; mask changes elsewhere take effect only at the next sweep boundary.
    - Sets prime=1 and selects the lowest set channel as cfg_ch; goes to CONV.
  - CONV: adc_convst=1 for exactly CONV_CYCLES cycles, then SHIFT.
  - SHIFT: adc_convst=0 for 12 SCLK periods (24*CLK_DIV cycles).
    - Each period: CLK_DIV cycles low, then CLK_DIV cycles high.
    - adc_din carries cfg word {1, cfg_ch[0], cfg_ch[2], cfg_ch[1], unipolar, 0} MSB first, driven from SHIFT entry and updated on each SCLK falling edge; it is 0 after bit 5.
    - adc_dout is sampled on the clock in which adc_sclk goes high and shifted into a 12-bit register, MSB first.
    - After the 12th high half, adc_sclk returns low and the state goes to EMIT.
  - EMIT (≥1 cycle, CONVST low):
    - If prime=1: discard the data, clear prime, advance, and go to CONV.
    - Otherwise: load result_data, and load result_chan = res_ch (the previous frame's cfg_ch), then assert result_valid.
    - Hold in EMIT until result_valid && result_ready, then advance.
  - Advance:
    - res_ch←cfg_ch.
    - If channels remain in the sweep, cfg_ch←next higher set bit of sweep_mask and go to CONV.
    - At sweep end, either re-latch chan_mask and cfg_ch←its lowest set bit (continuous=1 and chan_mask≠0), or go to IDLE after a final frame.
  - End of sweep: the frame converting the last channel still needs one more frame to read it out. That trailing frame shifts the config of cfg_ch = lowest set bit of the next mask (or CH0 if stopping) and its result is emitted.
- Frames per single sweep = popcount(mask)+1; results = popcount(mask), ascending channel order.
- Frame period without backpressure = CONV_CYCLES + 24*CLK_DIV + 1 cycles (129 at defaults).
- result_valid deassert: one cycle after handshake. Data and channel are stable while valid && !ready.
- Backpressure: SCLK/CONVST are frozen (low) while stalled in EMIT; no result is ever dropped.
- continuous falling mid-sweep: current sweep completes, then IDLE. start while busy: ignored.
- Mask becoming 0 at a continuous boundary: finish the trailing frame, then go to IDLE.

Test Plan:
- Single sweep, mask=8'b0000_0101, adc_dout model returns 12'hA5A for CH0 and 12'h3C3 for CH2 → 3 frames (387 cycles). DIN words are 6'b100010 (CH0), 6'b100110 (CH2), 6'b100010. Results are (CH0,A5A), then (CH2,3C3). busy returns to 0 after the last EMIT.
- Timing check at defaults → CONVST high exactly 80 cycles, 12 SCLK pulses of 2 high / 2 low cycles, adc_din stable across each rising edge, ≥1 low cycle between SHIFT end and next CONVST.
- Backpressure: result_ready=0 for 50 cycles on the first result → result_valid/data/chan held constant and no SCLK/CONVST activity. The next frame starts the cycle after the handshake, and no results are lost.
- Continuous, mask=8'hFF, unipolar=1 → channels emitted 0..7,0..7 with no priming frame between sweeps. Clearing continuous mid-sweep yields remaining channels then IDLE.
- Mask=0 with start → stays IDLE, busy=0, no bus activity. A start pulse during SHIFT is ignored.
- Assert reset_reset_n low mid-SHIFT → all outputs 0 asynchronously. After release, a start reruns the priming frame and the first result is correct.

Source files
------------

// File: rtl/ltc2308_scan_ctrl.sv
// LTC2308 scan sequencer: converts a masked channel set over SPI and streams the
// results, absorbing the ADC's one-frame lag between config word and conversion data.
module ltc2308_scan_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [7:0]  chan_mask,
    input  logic        unipolar,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [11:0] result_data,
    output logic [2:0]  result_chan,
    output logic        adc_convst,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout
);

    localparam logic [9:0] CONV_M1 = 10'(CONV_CYCLES - 1);
    localparam logic [9:0] HALF_M1 = 10'(CLK_DIV - 1);
    localparam logic [9:0] FULL_M1 = 10'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_SHIFT,
        ST_EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sweep_mask_q, sweep_mask_d;
    logic [2:0]  cfg_ch_q, cfg_ch_d;
    logic [2:0]  res_ch_q, res_ch_d;
    logic        prime_q, prime_d;
    logic        last_q, last_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [11:0] shreg_q, shreg_d;
    logic        convst_q, convst_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [11:0] data_q, data_d;
    logic [2:0]  chan_q, chan_d;

    logic [5:0]  cfg_word;
    logic [3:0]  nxt_ch;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (m[3'(i - 1)]) r = 3'(i - 1);
        end
        return r;
    endfunction

    // {found, channel} of the lowest set bit strictly above cur
    function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (m[3'(i - 1)] && ((i - 1) > 32'(cur))) r = {1'b1, 3'(i - 1)};
        end
        return r;
    endfunction

    function automatic logic cfg_bit(input logic [5:0] w, input logic [3:0] idx);
        logic b;
        b = 1'b0;
        if (idx < 4'd6) b = w[3'd5 - idx[2:0]];
        return b;
    endfunction

    always_comb begin
        cfg_word     = {1'b1, cfg_ch_q[0], cfg_ch_q[2], cfg_ch_q[1], unipolar, 1'b0};
        nxt_ch       = next_ch(sweep_mask_q, cfg_ch_q);

        state_d      = state_q;
        sweep_mask_d = sweep_mask_q;
        cfg_ch_d     = cfg_ch_q;
        res_ch_d     = res_ch_q;
        prime_d      = prime_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        convst_d     = convst_q;
        sclk_d       = sclk_q;
        din_d        = din_q;
        valid_d      = valid_q;
        data_d       = data_q;
        chan_d       = chan_q;

        unique case (state_q)
            ST_IDLE: begin
                if ((start || continuous) && (chan_mask != '0)) begin
                    state_d      = ST_CONV;
                    sweep_mask_d = chan_mask;
                    cfg_ch_d     = lowest_ch(chan_mask);
                    prime_d      = 1'b1;
                    last_d       = 1'b0;
                    cnt_d        = '0;
                    convst_d     = 1'b1;
                end
            end

            ST_CONV: begin
                if (cnt_q == CONV_M1) begin
                    state_d  = ST_SHIFT;
                    convst_d = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    din_d    = cfg_bit(cfg_word, 4'd0);
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            ST_SHIFT: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == HALF_M1) begin
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[10:0], adc_dout};
                end
                if (cnt_q == FULL_M1) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bit_q == 4'd11) begin
                        state_d = ST_EMIT;
                        din_d   = 1'b0;
                        if (!prime_q) begin
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                            chan_d  = res_ch_q;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        din_d = cfg_bit(cfg_word, bit_q + 4'd1);
                    end
                end
            end

            ST_EMIT: begin
                if (prime_q || (valid_q && result_ready)) begin
                    prime_d  = 1'b0;
                    valid_d  = 1'b0;
                    res_ch_d = cfg_ch_q;
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_CONV;
                        convst_d = 1'b1;
                        cnt_d    = '0;
                        if (nxt_ch[3]) begin
                            cfg_ch_d = nxt_ch[2:0];
                        end else if (continuous && (chan_mask != '0)) begin
                            // the trailing frame of this sweep doubles as the first of the next
                            sweep_mask_d = chan_mask;
                            cfg_ch_d     = lowest_ch(chan_mask);
                        end else begin
                            last_d   = 1'b1;
                            cfg_ch_d = '0;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            sweep_mask_q <= '0;
            cfg_ch_q     <= '0;
            res_ch_q     <= '0;
            prime_q      <= 1'b0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            convst_q     <= 1'b0;
            sclk_q       <= 1'b0;
            din_q        <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            chan_q       <= '0;
        end else begin
            state_q      <= state_d;
            sweep_mask_q <= sweep_mask_d;
            cfg_ch_q     <= cfg_ch_d;
            res_ch_q     <= res_ch_d;
            prime_q      <= prime_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            convst_q     <= convst_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            chan_q       <= chan_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result_data  = data_q;
    assign result_chan  = chan_q;
    assign adc_convst   = convst_q;
    assign adc_sclk     = sclk_q;
    assign adc_din      = din_q;

endmodule
